// File: rtl/axis_fifo_pkg.sv
// Shared types and sizing helpers for the AXI-Stream handshake FIFO.
package axis_fifo_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefUserWidth = 1;

  // One stream beat at the default widths.
  typedef struct packed {
    logic [DefDataWidth-1:0] tdata;
    logic [DefUserWidth-1:0] tuser;
    logic                    tlast;
  } axis_beat_t;

  // Level counts RAM words plus the output register: 0..fifo_len+1.
  function automatic int unsigned calc_lvl_width(input int unsigned fifo_len);
    return $clog2(fifo_len + 2);
  endfunction

  // RAM address width; pointers carry one extra wrap bit on top of this.
  function automatic int unsigned calc_ptr_width(input int unsigned fifo_len);
    return $clog2(fifo_len);
  endfunction

endpackage

// File: rtl/axis_fifo_hs_sdp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read so the head word
// is available in the same cycle it is addressed (first-word fall-through).
module axis_fifo_hs_sdp_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port; storage is never reset so it maps onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo_hs.sv
// Single-clock AXI-Stream FIFO: RAM plus one output register, full handshaking,
// fill level, almost-full/almost-empty flags and optional drop-when-full mode.
module axis_fifo_hs
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned USER_WIDTH       = 1,
  parameter int unsigned FIFO_LEN         = 16,
  parameter int unsigned ALMOST_FULL_LVL  = FIFO_LEN - 2,
  parameter int unsigned ALMOST_EMPTY_LVL = 2,
  parameter bit          DROP_WHEN_FULL   = 1'b0,
  localparam int unsigned LVL_WIDTH       = calc_lvl_width(FIFO_LEN)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] s_axis_in_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_in_tuser,
  input  logic                  s_axis_in_tlast,
  input  logic                  s_axis_in_tvalid,
  output logic                  s_axis_in_tready,
  output logic [DATA_WIDTH-1:0] m_axis_out_tdata,
  output logic [USER_WIDTH-1:0] m_axis_out_tuser,
  output logic                  m_axis_out_tlast,
  output logic                  m_axis_out_tvalid,
  input  logic                  m_axis_out_tready,
  output logic [LVL_WIDTH-1:0]  m_axis_out_tlevel,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int unsigned PtrWidth = calc_ptr_width(FIFO_LEN);
  localparam int unsigned PtrFull  = PtrWidth + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } beat_t;

  logic [PtrWidth:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  beat_t                in_beat, ram_rdata, out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 full_q, full_d;
  logic                 tready_q, tready_d;
  logic [LVL_WIDTH-1:0] level_q, level_d;
  logic                 afull_q, afull_d, aempty_q, aempty_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic in_ready, wr_ok, dropped, pop, load, ram_rd, bypass, ram_we;

  assign in_beat = '{tdata: s_axis_in_tdata, tuser: s_axis_in_tuser, tlast: s_axis_in_tlast};

  // Drop mode never stalls the source; full_q decides whether a beat is kept.
  assign in_ready = DROP_WHEN_FULL ? 1'b1 : tready_q;
  assign wr_ok    = s_axis_in_tvalid && in_ready && !full_q && !clear_i;
  assign dropped  = DROP_WHEN_FULL && s_axis_in_tvalid && full_q && !clear_i;
  assign pop      = out_valid_q && m_axis_out_tready;
  assign load     = !out_valid_q || pop;
  // RAM head has priority; an incoming beat bypasses the RAM only when it is empty.
  assign ram_rd   = load && (wr_ptr_q != rd_ptr_q);
  assign bypass   = load && (wr_ptr_q == rd_ptr_q) && wr_ok;
  assign ram_we   = wr_ok && !bypass;

  axis_fifo_hs_sdp_ram #(
    .Width ($bits(beat_t)),
    .Depth (FIFO_LEN)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[PtrWidth-1:0]),
    .wdata_i (in_beat),
    .raddr_i (rd_ptr_q[PtrWidth-1:0]),
    .rdata_o (ram_rdata)
  );

  // Next state for pointers, output register, level and status; clear flushes.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PtrFull'(ram_we);
    rd_ptr_d    = rd_ptr_q + PtrFull'(ram_rd);
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (load) begin
      if (ram_rd) begin
        out_d       = ram_rdata;
        out_valid_d = 1'b1;
      end else if (bypass) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    level_d    = level_q + LVL_WIDTH'(wr_ok) - LVL_WIDTH'(pop);
    ovf_d      = ovf_q | dropped;
    drop_cnt_d = (dropped && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      level_d     = '0;
      ovf_d       = 1'b0;
      drop_cnt_d  = '0;
    end

    // MSBs differ with equal low bits: RAM holds exactly FIFO_LEN words.
    full_d   = (wr_ptr_d[PtrWidth] != rd_ptr_d[PtrWidth]) &&
               (wr_ptr_d[PtrWidth-1:0] == rd_ptr_d[PtrWidth-1:0]);
    tready_d = !full_d;
    afull_d  = 32'(level_d) >= ALMOST_FULL_LVL;
    aempty_d = 32'(level_d) <= ALMOST_EMPTY_LVL;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
      tready_q    <= 1'b0;
      level_q     <= '0;
      afull_q     <= (ALMOST_FULL_LVL == 0);
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
      tready_q    <= tready_d;
      level_q     <= level_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign s_axis_in_tready  = in_ready;
  assign m_axis_out_tdata  = out_q.tdata;
  assign m_axis_out_tuser  = out_q.tuser;
  assign m_axis_out_tlast  = out_q.tlast;
  assign m_axis_out_tvalid = out_valid_q;
  assign m_axis_out_tlevel = level_q;
  assign almost_full_o     = afull_q;
  assign almost_empty_o    = aempty_q;
  assign overflow_o        = ovf_q;
  assign drop_cnt_o        = drop_cnt_q;

endmodule

// File: tb/tb_axis_fifo_hs.sv
// Scoreboard bench for axis_fifo_hs: three instances (backpressure depth 4,
// drop mode depth 4, backpressure depth 16) driven one at a time.
module tb_axis_fifo_hs;
  import axis_fifo_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [N], clr [N], s_valid [N], s_last [N], s_ready [N];
  logic        m_ready [N], m_valid [N], m_last [N], af [N], ae [N], ovf [N];
  logic [15:0] s_data [N], m_data [N], dcnt [N];
  logic [0:0]  s_user [N], m_user [N];
  logic [4:0]  lvl [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [calc_lvl_width(g == 2 ? 16 : 4)-1:0] lv;
    axis_fifo_hs #(
      .FIFO_LEN       (g == 2 ? 16 : 4),
      .DROP_WHEN_FULL (g == 1)
    ) u_dut (
      .clk_i             (clk),
      .reset_ni          (rst_n[g]),
      .clear_i           (clr[g]),
      .s_axis_in_tdata   (s_data[g]),
      .s_axis_in_tuser   (s_user[g]),
      .s_axis_in_tlast   (s_last[g]),
      .s_axis_in_tvalid  (s_valid[g]),
      .s_axis_in_tready  (s_ready[g]),
      .m_axis_out_tdata  (m_data[g]),
      .m_axis_out_tuser  (m_user[g]),
      .m_axis_out_tlast  (m_last[g]),
      .m_axis_out_tvalid (m_valid[g]),
      .m_axis_out_tready (m_ready[g]),
      .m_axis_out_tlevel (lv),
      .almost_full_o     (af[g]),
      .almost_empty_o    (ae[g]),
      .overflow_o        (ovf[g]),
      .drop_cnt_o        (dcnt[g])
    );
    assign lvl[g] = 5'(lv);
  end

  // Reference model state for the selected instance: a queue of beats held,
  // with the occupancy equal to its size.
  int unsigned sel;
  int unsigned count;
  bit          rst_hold;
  int unsigned drops;
  bit          ovf_m;
  bit          last_acc;
  axis_beat_t  exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int unsigned flen(input int unsigned i);
    return (i == 2) ? 16 : 4;
  endfunction

  function automatic bit is_drop(input int unsigned i);
    return i == 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (dut %0d, t=%0t): got %0h, required %0h", name, sel, $time, act, exp);
    end
  endtask

  task automatic model_init();
    count    = 0;
    rst_hold = 1'b0;
    drops    = 0;
    ovf_m    = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_status();
    int unsigned cap;
    cap = flen(sel) + 1;
    chk("tvalid", 32'(m_valid[sel]), 32'(count > 0));
    chk("tlevel", 32'(lvl[sel]), count);
    chk("tready", 32'(s_ready[sel]), is_drop(sel) ? 32'd1 : 32'(count < cap && !rst_hold));
    chk("almost_full", 32'(af[sel]), 32'(count >= flen(sel) - 2));
    chk("almost_empty", 32'(ae[sel]), 32'(count <= 2));
    chk("overflow", 32'(ovf[sel]), 32'(ovf_m));
    chk("drop_cnt", 32'(dcnt[sel]), drops);
    if (count > 0) chk("out_hold", 32'({m_data[sel], m_user[sel], m_last[sel]}), 32'(exp_q[0]));
  endtask

  // One clock: drive inputs, check status, then advance the model at the edge.
  task automatic step(input bit v, input logic [15:0] d, input bit u, input bit l,
                      input bit mt, input bit c, input bit r);
    int unsigned cap;
    bit pop, drp;
    axis_beat_t b;
    cap          = flen(sel) + 1;
    s_valid[sel] = v;
    s_data[sel]  = d;
    s_user[sel]  = u;
    s_last[sel]  = l;
    m_ready[sel] = mt;
    clr[sel]     = c;
    rst_n[sel]   = !r;
    #1;
    check_status();
    @(posedge clk);
    last_acc = 1'b0;
    if (r || c) begin
      exp_q.delete();
      count    = 0;
      drops    = 0;
      ovf_m    = 1'b0;
      rst_hold = r;
    end else begin
      last_acc = v && (count < cap) && !(rst_hold && !is_drop(sel));
      drp      = v && is_drop(sel) && (count == cap);
      pop      = (count > 0) && mt;
      if (last_acc) begin
        b.tdata = d;
        b.tuser = u;
        b.tlast = l;
        exp_q.push_back(b);
      end
      count = count + 32'(last_acc) - 32'(pop);
      if (drp) begin
        ovf_m = 1'b1;
        if (drops != 32'hFFFF) drops++;
      end
      rst_hold = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input bit mt);
    step(1'b0, 16'h0, 1'b0, 1'b0, mt, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    model_init();
    step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_tdata", 32'(m_data[sel]), 32'd0);
    chk("reset_tlast", 32'(m_last[sel]), 32'd0);
  endtask

  // Monitor: every completed read is matched against the scoreboard head.
  initial begin
    axis_beat_t b;
    forever begin
      @(negedge clk);
      if (m_valid[sel] === 1'b1 && m_ready[sel] === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_beat (dut %0d): got unexpected beat %0h, required none", sel,
                   {m_data[sel], m_user[sel], m_last[sel]});
        end else begin
          b = exp_q.pop_front();
          chk("out_beat", 32'({m_data[sel], m_user[sel], m_last[sel]}), 32'(b));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n_acc;
    int lvl_max;
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; clr[i] = 1'b0; s_valid[i] = 1'b0; s_last[i] = 1'b0;
      m_ready[i] = 1'b0; s_data[i] = '0; s_user[i] = '0;
    end
    sel = 0;
    model_init();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure, depth 4: fill past capacity, then drain in order.
    sel = 0;
    do_reset();
    idle(1'b0);
    for (int i = 1; i <= 6; i++) step(1'b1, 16'(i), 1'(i % 2), (i == 3) || (i == 5), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    repeat (7) idle(1'b1);
    chk("drain_bp4", 32'(exp_q.size()), 32'd0);

    // Bypass into an empty FIFO, held while stalled.
    step(1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Clear with a beat presented in the same cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    step(1'b1, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Drop mode, depth 4: eight beats into a stalled FIFO, then random traffic.
    sel = 1;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h200 + i), 1'b0, i == 7, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) == 0), $urandom_range(0, 49) == 0, 1'b0);
    repeat (8) idle(1'b1);
    chk("drain_drop", 32'(exp_q.size()), 32'd0);

    // Depth 16: long random stream against the scoreboard.
    sel = 2;
    do_reset();
    idle(1'b0);
    n_acc   = 0;
    lvl_max = 0;
    for (int i = 0; i < 6000 && n_acc < 1000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (last_acc) n_acc++;
      if (int'(lvl[2]) > lvl_max) lvl_max = int'(lvl[2]);
    end
    chk("level_bound", 32'(lvl_max <= 17), 32'd1);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1'b1);
    chk("drain_stream", 32'(exp_q.size()), 32'd0);

    // Reset with seven words stored, then a fresh write.
    for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h300 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h3FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("drain_after_reset", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
